// File: rtl/cmd_frame_assembler.sv
// cmd_frame_assembler
// Collects four MSB-first serial bytes into a 32-bit command word, presents it
// with a level trigger for downstream edge detection, and for read commands
// (opcode nibble 6) captures the addressed block's value after a fixed latency
// and returns it as four bytes over a valid/ready transmit port.
module cmd_frame_assembler #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TRIG_LEN       = 2,
  parameter int RESP_WAIT      = 6
) (
  input  logic        clk,
  input  logic        rest,
  input  logic [7:0]  rxData,
  input  logic        rxValid,
  output logic [31:0] cmdOut,
  output logic        cmdTrigger,
  input  logic [31:0] respValue,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady,
  output logic        frameErr,
  output logic        rxOverrun,
  output logic        busy
);

  localparam logic [3:0] OP_READ = 4'd6;
  localparam int GAP_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_MAX = (RESP_WAIT > TRIG_LEN) ? RESP_WAIT : TRIG_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_LEN - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RESP_WAIT - 1);
  // A latency no longer than the trigger pulse captures as the trigger ends.
  localparam bit CAPTURE_IN_TRIG = (RESP_WAIT <= TRIG_LEN);

  typedef enum logic [2:0] {S_IDLE, S_RX, S_TRIG, S_WAIT, S_TX} stateType;

  stateType         state, stateNext;
  logic [23:0]      shreg;      // only the three earlier bytes need holding
  logic [1:0]       byteCnt;
  logic [GAP_W-1:0] gapCnt;
  logic [CNT_W-1:0] phaseCnt;   // cycles since cmdTrigger rose, minus one
  logic [1:0]       txIdx;
  logic [31:0]      resp;

  logic acceptByte, frameDone, timeout, overrun, capture, txFire;

  assign busy       = (state != S_IDLE);
  assign cmdTrigger = (state == S_TRIG);
  assign txValid    = (state == S_TX);

  // Next-state decode and single-cycle control strobes for the datapath
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that forgot one would infer a latch.
    stateNext  = state;
    acceptByte = 1'b0;
    frameDone  = 1'b0;
    timeout    = 1'b0;
    overrun    = 1'b0;
    capture    = 1'b0;
    txFire     = 1'b0;
    case (state)
      S_IDLE: begin
        if (rxValid) begin
          acceptByte = 1'b1;
          stateNext  = S_RX;
        end
      end
      S_RX: begin
        if (rxValid) begin
          // A byte on the timeout cycle wins over the timeout.
          acceptByte = 1'b1;
          if (byteCnt == 2'd3) begin
            frameDone = 1'b1;
            stateNext = S_TRIG;
          end
        end else if (gapCnt == GAP_LAST) begin
          timeout   = 1'b1;
          stateNext = S_IDLE;
        end
      end
      S_TRIG: begin
        overrun = rxValid;
        if (phaseCnt == TRIG_LAST) begin
          if (cmdOut[31:28] != OP_READ) begin
            stateNext = S_IDLE;
          end else if (CAPTURE_IN_TRIG) begin
            capture   = 1'b1;
            stateNext = S_TX;
          end else begin
            stateNext = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        overrun = rxValid;
        if (phaseCnt == WAIT_LAST) begin
          capture   = 1'b1;
          stateNext = S_TX;
        end
      end
      S_TX: begin
        overrun = rxValid;
        if (txReady) begin
          txFire = 1'b1;
          if (txIdx == 2'd3) stateNext = S_IDLE;
        end
      end
      default: stateNext = S_IDLE;
    endcase
  end

  // Response byte select, most significant byte first; zero when not sending
  always_comb begin
    txData = 8'h00;
    if (state == S_TX) begin
      case (txIdx)
        2'd0:    txData = resp[31:24];
        2'd1:    txData = resp[23:16];
        2'd2:    txData = resp[15:8];
        default: txData = resp[7:0];
      endcase
    end
  end

  // State register, frame assembly, counters and registered status pulses
  always_ff @(posedge clk) begin
    if (rest) begin
      state     <= S_IDLE;
      shreg     <= '0;
      byteCnt   <= '0;
      gapCnt    <= '0;
      phaseCnt  <= '0;
      txIdx     <= '0;
      resp      <= '0;
      cmdOut    <= '0;
      frameErr  <= 1'b0;
      rxOverrun <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state     <= stateNext;
      frameErr  <= timeout;
      rxOverrun <= overrun;

      if (timeout)         shreg <= '0;
      else if (acceptByte) shreg <= {shreg[15:0], rxData};

      if (acceptByte)   byteCnt <= (state == S_IDLE) ? 2'd1 : byteCnt + 2'd1;
      else if (timeout) byteCnt <= '0;

      if (state == S_RX && !rxValid && !timeout) gapCnt <= gapCnt + 1'b1;
      else                                      gapCnt <= '0;

      // cmdOut moves only on a completed frame; downstream reads it late.
      if (frameDone) cmdOut <= {shreg, rxData};

      if (state == S_TRIG || state == S_WAIT) phaseCnt <= phaseCnt + 1'b1;
      else                                    phaseCnt <= '0;

      if (capture) resp <= respValue;

      // Wraps back to the first byte after the fourth handshake.
      if (txFire) txIdx <= txIdx + 2'd1;
    end
  end

endmodule

// File: tb/tb_cmd_frame_assembler.sv
// Testbench for cmd_frame_assembler: directed scenarios plus randomized
// frames, checked against a frame-level reference model (expected command
// words, trigger cycles, response bytes and pulse counts).
module tb_cmd_frame_assembler;

  localparam int TIMEOUT_CYCLES = 40;
  localparam int TRIG_LEN       = 2;
  localparam int RESP_WAIT      = 6;
  localparam int CYCLE_LIMIT    = 60000;

  logic        clk;
  logic        rest;
  logic [7:0]  rxData;
  logic        rxValid;
  logic [31:0] cmdOut;
  logic        cmdTrigger;
  logic [31:0] respValue;
  logic [7:0]  txData;
  logic        txValid;
  logic        txReady;
  logic        frameErr;
  logic        rxOverrun;
  logic        busy;

  cmd_frame_assembler #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TRIG_LEN      (TRIG_LEN),
    .RESP_WAIT     (RESP_WAIT)
  ) dut (
    .clk       (clk),
    .rest      (rest),
    .rxData    (rxData),
    .rxValid   (rxValid),
    .cmdOut    (cmdOut),
    .cmdTrigger(cmdTrigger),
    .respValue (respValue),
    .txData    (txData),
    .txValid   (txValid),
    .txReady   (txReady),
    .frameErr  (frameErr),
    .rxOverrun (rxOverrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle number: during cycle k (after rising edge k) cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Response source; when tagged, the value identifies the cycle it was sampled in.
  logic        respTagged;
  logic [31:0] respBase;
  assign respValue = respTagged ? (respBase ^ 32'(cyc)) : respBase;

  int nChecks = 0;
  int nPass   = 0;

  // Reference model state
  logic [31:0] expCmd[$];
  int          expTrigCyc[$];
  logic [7:0]  expTx[$];
  int          expTxCyc[$];
  logic [31:0] lastCmd;
  int          expErr = 0;
  int          expOv  = 0;
  int          errCount = 0;
  int          ovCount  = 0;

  // Transmit-ready behaviour: 0 always ready, 1 random, 2 ten stall cycles per byte, 3 never
  int readyMode = 0;
  int bpCnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: observed 0x%0h required 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic atNeg(input int c);
    while (cyc < c) step();
    @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] b);
    rxData  = b;
    rxValid = 1'b1;
    step();
    rxValid = 1'b0;
  endtask

  // Sends a frame with 'gap' idle cycles between bytes; n is the 4th byte's cycle.
  task automatic sendFrame(input logic [31:0] word, input int gap, output int n);
    logic [31:0] resp;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) repeat (gap) step();
      if (i == 3) begin
        n = cyc;
        expCmd.push_back(word);
        expTrigCyc.push_back(n + 1);
        lastCmd = word;
        if (word[31:28] == 4'd6) begin
          resp = respTagged ? (respBase ^ 32'(n + RESP_WAIT)) : respBase;
          expTxCyc.push_back(n + RESP_WAIT + 1);
          for (int j = 3; j >= 0; j--) expTx.push_back(resp[8*j +: 8]);
        end
      end
      sendByte(word[8*(3-i) +: 8]);
    end
  endtask

  // Waits until the model says the block is idle again (bounded for reads).
  task automatic waitDone(input int n, input bit isRead);
    int budget;
    step();
    while (cyc < n + TRIG_LEN + 1) step();
    if (isRead) begin
      budget = 2000;
      while (expTx.size() > 0 && budget > 0) begin
        step();
        budget--;
      end
      check("tx_drain", expTx.size(), 0);
      expTx.delete();
      expTxCyc.delete();
    end
  endtask

  task automatic checkResetValues(input string pfx);
    check({pfx, "_cmdOut"},     cmdOut,     32'h0);
    check({pfx, "_cmdTrigger"}, cmdTrigger, 1'b0);
    check({pfx, "_txValid"},    txValid,    1'b0);
    check({pfx, "_txData"},     txData,     8'h00);
    check({pfx, "_frameErr"},   frameErr,   1'b0);
    check({pfx, "_rxOverrun"},  rxOverrun,  1'b0);
    check({pfx, "_busy"},       busy,       1'b0);
  endtask

  // Transmit-side flow control, applied just after the input-drive point
  initial begin
    txReady = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (readyMode)
        0: txReady = 1'b1;
        1: txReady = ($urandom_range(0, 2) != 0);
        2: begin
          if (txValid && bpCnt < 10) begin
            txReady = 1'b0;
            bpCnt++;
          end else begin
            txReady = 1'b1;
            bpCnt = 0;
          end
        end
        default: txReady = 1'b0;
      endcase
    end
  end

  // Output monitor: trigger, command word and response stream against the model
  logic       trigPrev = 1'b0;
  logic       txvPrev = 1'b0;
  logic       stallPrev = 1'b0;
  logic [7:0] dataPrev = 8'h00;
  int         trigLen = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rest) begin
        trigPrev = 1'b0;
        txvPrev = 1'b0;
        stallPrev = 1'b0;
        trigLen = 0;
      end else begin
        if (frameErr) errCount++;
        if (rxOverrun) ovCount++;
        if (cmdTrigger && !trigPrev) begin
          check("trig_expected", expCmd.size() > 0, 1'b1);
          if (expCmd.size() > 0) begin
            check("cmd_word", cmdOut, expCmd.pop_front());
            check("trig_cycle", cyc, expTrigCyc.pop_front());
          end
          trigLen = 0;
        end
        if (cmdTrigger) trigLen++;
        if (!cmdTrigger && trigPrev) check("trig_len", trigLen, TRIG_LEN);
        trigPrev = cmdTrigger;
        if (stallPrev) begin
          check("tx_hold_valid", txValid, 1'b1);
          check("tx_hold_data", txData, dataPrev);
        end
        if (txValid && !txvPrev) begin
          check("tx_start_expected", expTxCyc.size() > 0, 1'b1);
          if (expTxCyc.size() > 0) check("tx_start_cycle", cyc, expTxCyc.pop_front());
        end
        if (txValid && txReady) begin
          check("tx_expected", expTx.size() > 0, 1'b1);
          if (expTx.size() > 0) check("tx_byte", txData, expTx.pop_front());
        end
        stallPrev = txValid && !txReady;
        dataPrev  = txData;
        txvPrev   = txValid;
      end
    end
  end

  // Hard stop if anything hangs
  initial begin
    #(CYCLE_LIMIT * 10);
    $display("FAIL watchdog: no finish after %0d cycles", CYCLE_LIMIT);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int b;
    int k;
    logic [31:0] w;

    rest = 1'b1;
    rxValid = 1'b0;
    rxData = 8'h00;
    respTagged = 1'b0;
    respBase = 32'h0;
    lastCmd = 32'h0;
    readyMode = 0;

    // Reset values
    repeat (3) step();
    @(negedge clk);
    checkResetValues("reset");
    step();
    rest = 1'b0;
    step();

    // Write frame: no response, trigger for TRIG_LEN cycles
    sendFrame(32'h7100_0005, 0, n);
    atNeg(n + 2);
    check("wr_busy_mid", busy, 1'b1);
    atNeg(n + 3);
    check("wr_busy_done", busy, 1'b0);
    check("wr_trig_low", cmdTrigger, 1'b0);
    waitDone(n, 1'b0);

    // Read frame with a fixed return value
    respTagged = 1'b0;
    respBase = 32'h0000_0015;
    sendFrame(32'h6100_0000, 0, n);
    atNeg(n + RESP_WAIT + 4);
    check("rd_tx_last", txValid, 1'b1);
    atNeg(n + RESP_WAIT + 5);
    check("rd_tx_done", txValid, 1'b0);
    check("rd_busy_done", busy, 1'b0);
    check("rd_tx_left", expTx.size(), 0);
    waitDone(n, 1'b1);

    // Byte arriving on the timeout cycle is accepted
    sendFrame(32'h7122_3344, TIMEOUT_CYCLES - 1, n);
    waitDone(n, 1'b0);
    check("gap_edge_err", errCount, expErr);

    // Abandoned partial frame, then recovery
    sendByte(8'hAA);
    sendByte(8'hBB);
    b = cyc - 1;
    atNeg(b + TIMEOUT_CYCLES);
    check("to_err_early", frameErr, 1'b0);
    check("to_busy_wait", busy, 1'b1);
    atNeg(b + TIMEOUT_CYCLES + 1);
    check("to_err_pulse", frameErr, 1'b1);
    check("to_cmd_hold", cmdOut, lastCmd);
    check("to_idle", busy, 1'b0);
    expErr++;
    step();
    sendFrame(32'h7100_0003, 0, n);
    waitDone(n, 1'b0);
    check("to_err_count", errCount, expErr);

    // Backpressure: ten stall cycles ahead of every byte
    respTagged = 1'b1;
    respBase = 32'hC0DE_5A00;
    readyMode = 2;
    sendFrame(32'h6300_0010, 0, n);
    waitDone(n, 1'b1);
    readyMode = 0;

    // Overrun: bytes during S_TRIG, S_WAIT and S_TX of a read
    respBase = 32'h1234_0000;
    sendFrame(32'h6200_0020, 0, n);
    while (cyc < n + 2) step();
    sendByte(8'h5A);
    atNeg(n + 3);
    check("ov_pulse", rxOverrun, 1'b1);
    step();
    sendByte(8'hA5);
    while (cyc < n + 8) step();
    sendByte(8'h3C);
    expOv += 3;
    waitDone(n, 1'b1);
    check("ov_count", ovCount, expOv);
    check("ov_cmd_hold", cmdOut, lastCmd);

    // Reset after the second response byte
    respBase = 32'h89AB_CDEF;
    sendFrame(32'h6500_0001, 0, n);
    while (cyc < n + RESP_WAIT + 3) step();
    check("mid_two_sent", expTx.size(), 2);
    rest = 1'b1;
    readyMode = 3;
    step();
    rest = 1'b0;
    expTx.delete();
    expTxCyc.delete();
    lastCmd = 32'h0;
    @(negedge clk);
    checkResetValues("mid_reset");
    readyMode = 0;
    repeat (10) step();
    check("mid_no_tx", txValid, 1'b0);
    sendFrame(32'h7100_0007, 0, n);
    waitDone(n, 1'b0);
    sendFrame(32'h6000_00AB, 0, n);
    waitDone(n, 1'b1);

    // Randomized frames, gaps, flow control and abandoned frames
    for (int i = 0; i < 40; i++) begin
      respBase = $urandom();
      readyMode = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(1, 3);
        for (int j = 0; j < k; j++) sendByte(8'($urandom()));
        b = cyc - 1;
        atNeg(b + TIMEOUT_CYCLES + 1);
        check("rnd_err_pulse", frameErr, 1'b1);
        check("rnd_cmd_hold", cmdOut, lastCmd);
        expErr++;
        step();
      end else begin
        w = $urandom();
        if ($urandom_range(0, 1) == 1) w[31:28] = 4'd6;
        k = ($urandom_range(0, 5) == 0) ? TIMEOUT_CYCLES - 1 : $urandom_range(0, 3);
        sendFrame(w, k, n);
        waitDone(n, w[31:28] == 4'd6);
      end
    end

    readyMode = 0;
    repeat (5) step();
    check("end_err_count", errCount, expErr);
    check("end_ov_count", ovCount, expOv);
    check("end_cmd_queue", expCmd.size(), 0);
    check("end_tx_queue", expTx.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
